// File: rtl/alu_exec_ctrl.sv
// Sequencing front-end for the 32-bit ALU: accepts one instruction per handshake,
// drives registered operands to the ALU, and writes back the result and PSW.
module alu_exec_ctrl #(
  parameter int SIZE = 32,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_bsel,
  input  logic [SIZE-1:0] in_imm,
  input  logic            in_wen,
  output logic [3:0]      alu_op,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  input  logic [SIZE-1:0] alu_f,
  input  logic [4:0]      alu_flags,
  output logic [4:0]      psw,
  output logic            done,
  input  logic [AW-1:0]   dbg_addr,
  output logic [SIZE-1:0] dbg_data
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] regs [NREG];
  logic [AW-1:0]   rd_q;
  logic            wen_q;
  logic [SIZE-1:0] res_q;
  logic [4:0]      flg_q;
  logic            op_undef;

  // Handshake: an instruction is taken on any rising edge where in_valid && in_ready;
  // in_ready depends only on the state register, and in_* are ignored otherwise.
  assign in_ready = (state == IDLE);
  assign dbg_data = regs[dbg_addr];

  // alu_op holds the accepted opcode through WB, so it doubles as the latched op.
  assign op_undef = (alu_op == 4'b1001) || (alu_op == 4'b1011);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      regs   <= '{default: '0};
      rd_q   <= '0;
      wen_q  <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      psw    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            rd_q   <= in_rd;
            wen_q  <= in_wen;
            alu_op <= in_op;
            alu_a  <= regs[in_rs1];
            alu_b  <= in_bsel ? in_imm : regs[in_rs2];
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q <= alu_f;
          flg_q <= alu_flags;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          // Undefined opcodes still sequence and pulse done but leave state untouched.
          if (!op_undef) begin
            psw <= flg_q;
            if (wen_q) regs[rd_q] <= res_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU in the loop, reference register file/PSW
// model, directed scenarios followed by randomized instructions.
module tb_alu_exec_ctrl;
  localparam int SIZE = 32;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [AW-1:0]   in_rd, in_rs1, in_rs2;
  logic            in_bsel;
  logic [SIZE-1:0] in_imm;
  logic            in_wen;
  logic [3:0]      alu_op;
  logic [SIZE-1:0] alu_a, alu_b, alu_f;
  logic [4:0]      alu_flags;
  logic [4:0]      psw;
  logic            done;
  logic [AW-1:0]   dbg_addr;
  logic [SIZE-1:0] dbg_data;

  alu_exec_ctrl #(.SIZE(SIZE), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_bsel(in_bsel), .in_imm(in_imm), .in_wen(in_wen),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_flags(alu_flags), .psw(psw), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {SF,ZF,CF,OF,PF, F}
  function automatic logic [36:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] f;
    logic        cf, of;
    cf = 1'b0; of = 1'b0; s = '0;
    case (op)
      4'b0100: begin
        s  = {1'b0, a} + {1'b0, b};
        f  = s[31:0];
        cf = s[32];
        of = (a[31] == b[31]) && (f[31] != a[31]);
      end
      4'b0010: begin
        f  = a - b;
        cf = (a < b);
        of = (a[31] != b[31]) && (f[31] != a[31]);
      end
      4'b1101: f = b;
      4'b0000: f = a & b;
      4'b0001: f = a | b;
      4'b0110: f = a ^ b;
      default: f = a ^ b ^ 32'hDEAD_BEEF;
    endcase
    return {f[31], (f == 32'd0), cf, of, ~^f[7:0], f};
  endfunction

  always_comb {alu_flags, alu_f} = alu_model(alu_op, alu_a, alu_b);

  logic [31:0] ref_regs [8];
  logic [4:0]  ref_psw;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_psw = '0;
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_data, ref_regs[i]);
    end
  endtask

  task automatic ref_apply(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic bsel, input logic [31:0] imm,
                           input logic wen, output logic [31:0] a, output logic [31:0] b);
    logic [36:0] r;
    a = ref_regs[rs1];
    b = bsel ? imm : ref_regs[rs2];
    r = alu_model(op, a, b);
    if (op != 4'b1001 && op != 4'b1011) begin
      ref_psw = r[36:32];
      if (wen) ref_regs[rd] = r[31:0];
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic bsel, input logic [31:0] imm,
                       input logic wen);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_bsel = bsel; in_imm = imm; in_wen = wen;
  endtask

  // One instruction with full timing checks through EXEC, WB and back to IDLE.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic bsel, input logic [31:0] imm,
                       input logic wen);
    logic [31:0] a, b;
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_issue", in_ready, 1);
    drive(op, rd, rs1, rs2, bsel, imm, wen);
    in_valid = 1'b1;
    ref_apply(op, rd, rs1, rs2, bsel, imm, wen, a, b);
    exp_q.push_back(ref_regs[rd]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_ready", in_ready, 0);
    chk("exec_done", done, 0);
    chk("alu_op", alu_op, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(posedge clk); #1;
    chk("wb_done", done, 1);
    chk("wb_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_ready", in_ready, 1);
    chk("psw", psw, ref_psw);
    dbg_addr = rd;
    #1;
    chk("wb_reg", dbg_data, exp_q.pop_front());
  endtask

  initial begin
    logic [3:0]  ops [8];
    logic [31:0] a, b;
    logic [4:0]  psw_save;
    int          n, low_cnt;
    ops = '{4'b0100, 4'b0010, 4'b1101, 4'b0000, 4'b0001, 4'b0110, 4'b1001, 4'b1011};
    rst_n = 1'b0; in_valid = 1'b0; dbg_addr = '0;
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0, 1'b0);
    ref_clear();

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_psw", psw, 0);
    sweep_regs("rst");

    // Loads via immediate
    issue(4'b1101, 3'd1, 3'd0, 3'd0, 1'b1, 32'h5, 1'b1);
    issue(4'b1101, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFB, 1'b1);
    dbg_addr = 3'd1; #1; chk("load_r1", dbg_data, 32'h5);
    dbg_addr = 3'd2; #1; chk("load_r2", dbg_data, 32'hFFFF_FFFB);

    // Add with carry-out to zero
    issue(4'b0100, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 1'b1);
    dbg_addr = 3'd3; #1; chk("add_r3", dbg_data, 32'h0);
    chk("add_psw", psw, 5'b01101);

    // Compare, flags only
    issue(4'b0010, 3'd1, 3'd1, 3'd1, 1'b0, 32'd0, 1'b0);
    dbg_addr = 3'd1; #1; chk("cmp_r1", dbg_data, 32'h5);
    chk("cmp_zf", psw[3], 1);

    // Back-to-back with in_valid held; second reads the first's destination
    @(negedge clk);
    drive(4'b0100, 3'd4, 3'd1, 3'd1, 1'b0, 32'd0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    ref_apply(4'b0100, 3'd4, 3'd1, 3'd1, 1'b0, 32'd0, 1'b1, a, b);
    drive(4'b0110, 3'd5, 3'd4, 3'd2, 1'b0, 32'd0, 1'b1);
    n = 0; low_cnt = 0;
    while (!in_ready && n < 10) begin
      low_cnt++;
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_edges", n + 1, 3);
    chk("b2b_low_cycles", low_cnt, 2);
    chk("b2b_second_taken", in_ready, 0);
    ref_apply(4'b0110, 3'd5, 3'd4, 3'd2, 1'b0, 32'd0, 1'b1, a, b);
    chk("b2b_alu_a", alu_a, 32'hA);
    chk("b2b_alu_b", alu_b, b);
    repeat (2) @(posedge clk);
    #1;
    sweep_regs("b2b");
    chk("b2b_psw", psw, ref_psw);

    // Reset during EXEC
    @(negedge clk);
    drive(4'b1101, 3'd6, 3'd0, 3'd0, 1'b1, 32'd77, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rexec_busy", in_ready, 0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rexec_ready", in_ready, 1);
    chk("rexec_done", done, 0);
    chk("rexec_psw", psw, 0);
    @(negedge clk); rst_n = 1'b1;
    ref_clear();
    @(posedge clk); #1;
    chk("rexec_done2", done, 0);
    sweep_regs("rexec");

    // Undefined op acts as NOP
    issue(4'b1101, 3'd1, 3'd0, 3'd0, 1'b1, 32'h5, 1'b1);
    issue(4'b0010, 3'd2, 3'd1, 3'd0, 1'b0, 32'd0, 1'b0);
    psw_save = psw;
    issue(4'b1001, 3'd1, 3'd1, 3'd1, 1'b0, 32'd0, 1'b1);
    dbg_addr = 3'd1; #1; chk("nop_r1", dbg_data, 32'h5);
    chk("nop_psw", psw, psw_save);

    // Randomized instructions
    for (int k = 0; k < 40; k++) begin
      issue(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 3) != 0));
    end
    sweep_regs("final");
    chk("final_psw", psw, ref_psw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
